// File: rtl/freq_pkg.sv
// Shared constants for the frequency meter front end: default filter/prescaler
// settings and the range switch encoding.
package freq_pkg;

  localparam int FILT_LEN_DEF = 3;
  localparam int DIV_DEF      = 10;

  localparam logic RANGE_X1  = 1'b0;
  localparam logic RANGE_DIV = 1'b1;

  typedef logic [3:0] cnt4_t;

endpackage

// File: rtl/sig_condition_if.sv
// Signal bundle between the test-signal source/gate controller and the
// conditioning front end.
interface sig_condition_if;

  logic sig_raw;
  logic range;
  logic clr;
  logic edge_pulse;
  logic sig_out;
  logic glitch;

  modport master (
    output sig_raw,
    output range,
    output clr,
    input  edge_pulse,
    input  sig_out,
    input  glitch
  );

  modport slave (
    input  sig_raw,
    input  range,
    input  clr,
    output edge_pulse,
    output sig_out,
    output glitch
  );

endinterface

// File: rtl/sig_condition_sync2.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sig_condition.sv
// Frequency meter input conditioning: synchronise, deglitch, detect rising
// edges and optionally prescale by DIV before the gate counter.
module sig_condition
  import freq_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF,
  parameter int DIV      = DIV_DEF
) (
  input  logic          sys_clk,
  input  logic          reset,
  sig_condition_if.slave bus
);

  localparam cnt4_t FILT_LEN_C = cnt4_t'(FILT_LEN);
  localparam cnt4_t PCNT_MAX   = cnt4_t'(DIV - 1);
  localparam cnt4_t PCNT_HALF  = cnt4_t'(DIV / 2);

  logic  s_sig;
  logic  s_rng;

  logic  filt_q, filt_d;
  cnt4_t run_q, run_d;
  logic  glitch_q, glitch_d;
  logic  filt_dly_q;
  logic  rng_prev_q;
  cnt4_t pcnt_q, pcnt_d;
  logic  edge_q, edge_d;
  logic  sig_out_q, sig_out_d;

  logic  rise;
  logic  rng_chg;

  sync2 u_sync_sig (
    .clk   (sys_clk),
    .rst_n (reset),
    .d_i   (bus.sig_raw),
    .q_o   (s_sig)
  );

  sync2 u_sync_rng (
    .clk   (sys_clk),
    .rst_n (reset),
    .d_i   (bus.range),
    .q_o   (s_rng)
  );

  // Filter: a new level is accepted only after FILT_LEN consecutive cycles.
  always_comb begin
    filt_d   = filt_q;
    run_d    = run_q;
    glitch_d = 1'b0;
    if (s_sig == filt_q) begin
      run_d    = '0;
      glitch_d = (run_q != '0);
    end else if (run_q + 4'd1 == FILT_LEN_C) begin
      filt_d = s_sig;
      run_d  = '0;
    end else begin
      run_d = run_q + 4'd1;
    end
  end

  assign rise    = filt_q & ~filt_dly_q;
  assign rng_chg = s_rng ^ rng_prev_q;

  // Prescaler: range change beats clr, which beats a counted rise.
  always_comb begin
    pcnt_d    = pcnt_q;
    edge_d    = 1'b0;
    sig_out_d = sig_out_q;
    if (rng_chg) begin
      pcnt_d    = '0;
      sig_out_d = 1'b0;
    end else if (s_rng == RANGE_X1) begin
      pcnt_d    = '0;
      sig_out_d = filt_q;
      edge_d    = rise & ~bus.clr;
    end else if (bus.clr) begin
      pcnt_d    = '0;
      sig_out_d = 1'b0;
    end else if (rise) begin
      if (pcnt_q == PCNT_MAX) begin
        pcnt_d    = '0;
        edge_d    = 1'b1;
        sig_out_d = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 4'd1;
        if (pcnt_q + 4'd1 == PCNT_HALF) begin
          sig_out_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      filt_q     <= 1'b0;
      run_q      <= '0;
      glitch_q   <= 1'b0;
      filt_dly_q <= 1'b0;
      rng_prev_q <= 1'b0;
      pcnt_q     <= '0;
      edge_q     <= 1'b0;
      sig_out_q  <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      run_q      <= run_d;
      glitch_q   <= glitch_d;
      filt_dly_q <= filt_q;
      rng_prev_q <= s_rng;
      pcnt_q     <= pcnt_d;
      edge_q     <= edge_d;
      sig_out_q  <= sig_out_d;
    end
  end

  assign bus.edge_pulse = edge_q;
  assign bus.sig_out    = sig_out_q;
  assign bus.glitch     = glitch_q;

endmodule

// File: tb/tb_sig_condition.sv
// Scoreboard bench for sig_condition: stimulus queues expected pulse/glitch
// cycles, a negedge monitor pops and compares them against the DUT outputs.
module tb_sig_condition;
  import freq_pkg::*;

  localparam int FL = FILT_LEN_DEF;
  localparam int DV = DIV_DEF;

  typedef struct {
    int   cyc;
    logic so;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  sig_condition_if bus ();

  sig_condition #(.FILT_LEN(FL), .DIV(DV)) dut (
    .sys_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  exp_t pq[$];
  int   gq[$];
  int   ncyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   pc = 0;
  bit   wrapped = 1'b0;
  bit   div_mode = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic expect_pulse(input int c);
    exp_t e;
    e.cyc = c;
    e.so  = 1'b1;
    pq.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    int now;
    now = ncyc + 1;
    ncyc <= now;
    if (reset) begin
      if (pq.size() > 0 && pq[0].cyc < now) begin
        vectors++;
        miscompares++;
        $display("FAIL pulse_missing: edge_pulse stayed 0, expected 1 at cycle %0d", pq[0].cyc);
        void'(pq.pop_front());
      end
      if (bus.edge_pulse) begin
        if (pq.size() > 0 && pq[0].cyc == now) begin
          check("pulse_sig_out", bus.sig_out, pq[0].so);
          void'(pq.pop_front());
        end else begin
          vectors++;
          miscompares++;
          $display("FAIL pulse_unexpected: edge_pulse=1 at cycle %0d, expected 0", now);
        end
      end
      if (gq.size() > 0 && gq[0] < now) begin
        vectors++;
        miscompares++;
        $display("FAIL glitch_missing: glitch stayed 0, expected 1 at cycle %0d", gq[0]);
        void'(gq.pop_front());
      end
      if (bus.glitch) begin
        vectors++;
        if (gq.size() > 0 && gq[0] == now) begin
          void'(gq.pop_front());
        end else begin
          miscompares++;
          $display("FAIL glitch_unexpected: glitch=1 at cycle %0d, expected 0", now);
        end
      end
    end
  end

  // One clean input period; entered and left just after a falling clock edge.
  task automatic period(input int h, input int l, input bit clr_hit);
    int n;
    n = ncyc;
    bus.sig_raw = 1'b1;
    if (clr_hit) begin
      pc = 0;
      wrapped = 1'b0;
    end else if (!div_mode) begin
      expect_pulse(n + FL + 3);
    end else begin
      pc++;
      if (pc == DV) begin
        pc = 0;
        wrapped = 1'b1;
        expect_pulse(n + FL + 3);
      end
    end
    for (int j = 1; j <= h; j++) begin
      @(negedge clk);
      #1;
      bus.clr = clr_hit && (j == FL + 2);
    end
    bus.clr = 1'b0;
    bus.sig_raw = 1'b0;
    repeat (l) @(negedge clk);
    #1;
    check("sig_out_period", bus.sig_out, div_mode ? logic'(wrapped && pc < DV / 2) : 1'b0);
  endtask

  task automatic glitch_pulse(input int h);
    gq.push_back(ncyc + h + 3);
    bus.sig_raw = 1'b1;
    repeat (h) @(negedge clk);
    #1;
    bus.sig_raw = 1'b0;
    repeat (12) @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_edge_pulse"}, bus.edge_pulse, 1'b0);
    check({tag, "_sig_out"}, bus.sig_out, 1'b0);
    check({tag, "_glitch"}, bus.glitch, 1'b0);
    bus.sig_raw = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    #1;
  endtask

  initial begin
    bus.sig_raw = 1'b0;
    bus.range   = RANGE_X1;
    bus.clr     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("por_edge_pulse", bus.edge_pulse, 1'b0);
    check("por_sig_out", bus.sig_out, 1'b0);
    check("por_glitch", bus.glitch, 1'b0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;

    // x1: latency and 20 clean periods
    for (int i = 0; i < 20; i++) period(10, 10, 1'b0);

    // glitch rejection, then a just-long-enough pulse
    for (int i = 0; i < 3; i++) glitch_pulse(2);
    glitch_pulse(1);
    period(FL, 10, 1'b0);

    // reset while the conditioned output is high
    expect_pulse(ncyc + FL + 3);
    bus.sig_raw = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("x1_level_high", bus.sig_out, 1'b1);
    reset_pulse("rst_high");

    // divide mode: 95 rises, then 5 more to prove the phase
    bus.range = RANGE_DIV;
    div_mode  = 1'b1;
    pc        = 0;
    wrapped   = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    for (int i = 0; i < 95; i++) period(10, 10, 1'b0);
    for (int i = 0; i < 5; i++) period(10, 10, 1'b0);

    // reset with the prescaler at 7
    for (int i = 0; i < 7; i++) period(10, 10, 1'b0);
    reset_pulse("rst_pcnt7");
    pc = 0;
    wrapped = 1'b0;
    for (int i = 0; i < DV; i++) period(10, 10, 1'b0);

    // clr colliding with a rise
    for (int i = 0; i < 3; i++) period(10, 10, 1'b0);
    period(10, 10, 1'b1);
    for (int i = 0; i < DV; i++) period(10, 10, 1'b0);

    // range switch with the prescaler at 4
    for (int i = 0; i < 4; i++) period(10, 10, 1'b0);
    bus.range = RANGE_X1;
    div_mode  = 1'b0;
    pc        = 0;
    wrapped   = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("range_switch_sig_out", bus.sig_out, 1'b0);
    for (int i = 0; i < 2; i++) period(10, 10, 1'b0);

    repeat (20) @(negedge clk);
    #1;
    while (pq.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pulse_leftover: edge_pulse never seen, expected at cycle %0d", pq[0].cyc);
      void'(pq.pop_front());
    end
    while (gq.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL glitch_leftover: glitch never seen, expected at cycle %0d", gq[0]);
      void'(gq.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sig_condition.md
# sig_condition

Input front end of the frequency meter: takes the raw, asynchronous measured signal and the range switch, and delivers clean, `sys_clk`-synchronous edge pulses to the gate counter. It synchronises the input, rejects glitches shorter than a programmable width, detects rising edges, and applies the decade prescaler selected by `range`. It sits directly between the test-signal source and the counting stage.

## Interface
- `FILT_LEN`, default 3: consecutive `sys_clk` cycles a new level must persist before it is accepted. Legal values are 1..15.
- `DIV`, default 10: prescaler ratio in high range. Legal values are even, 2..16.
- `sys_clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sig_raw`  in  1  measured signal, asynchronous to `sys_clk`.
- `range`  in  1  switch, asynchronous. 0 = ×1, 1 = ÷`DIV`.
- `clr`  in  1  synchronous, from the gate controller; restarts the prescaler phase.
- `edge_pulse`  out  1  one-cycle pulse per counted rising edge.
- `sig_out`  out  1  conditioned square wave. In ×1 it is the filtered level; in ÷`DIV` it is the divided square.
- `glitch`  out  1  one-cycle flag when a rejected pulse ends.

## Operation
- **Reset:** while `reset` is low, every flop is held at 0. This includes the synchronisers, the filter level and counter, the prescaler counter, `edge_pulse`, `sig_out` and `glitch`.
- **Synchronisers:**
  - `sig_raw` passes through a 2-flop synchroniser to give `s_sig`.
  - `range` passes through its own 2-flop synchroniser to give `s_rng`.
- **Filter:**
  - State is a level `filt` plus a run counter `run` of 4 bits.
  - If `s_sig` equals `filt`, `run` is set to 0.
  - Otherwise `run` increments. When `run` would reach `FILT_LEN`, `filt` takes the value of `s_sig` and `run` is set to 0.
  - `glitch` is a registered 1 for one cycle when `run` is nonzero and `s_sig` returns to `filt`.
- **Edge detect:** `rise` = `filt` & ~`filt_d`, where `filt_d` is `filt` delayed by one register.
- **Prescaler:**
  - `pcnt` is a counter over 0..`DIV`-1.
  - In ×1 mode: `edge_pulse` <= `rise`; `sig_out` <= `filt`; `pcnt` is held at 0.
  - In ÷`DIV` mode, on each `rise`:
    - If `pcnt` = `DIV`-1: `pcnt` <= 0, `edge_pulse` <= 1, `sig_out` <= 1.
    - Otherwise `pcnt` increments. When the new `pcnt` equals `DIV`/2, `sig_out` <= 0.
- **Range change** (`s_rng` differs from its previous value): `pcnt` <= 0, `sig_out` <= 0, and `edge_pulse` is suppressed that cycle.
- **`clr`:** `pcnt` <= 0 and `sig_out` <= 0 in ÷ mode. Any `rise` in the same cycle is dropped, so `edge_pulse` = 0 that cycle. The filter is unaffected.
- **Priority:** reset > range change > `clr` > `rise`.

## Timing
- Let k be the `sys_clk` edge at which the first sync flop captures a new `sig_raw` level:
  - `s_sig` changes at k+1.
  - `filt` flips at k+1+`FILT_LEN`.
  - `edge_pulse`/`sig_out` (×1) update at k+2+`FILT_LEN`.
  - Total latency is `FILT_LEN`+2 cycles after k. With the default this is 5.
- A level must persist for at least `FILT_LEN` cycles to be accepted. Maximum countable input is `sys_clk`/(2·`FILT_LEN`).
- `edge_pulse` is never high for 2 consecutive cycles.
- `range` takes effect 2 cycles after capture.

## Structure
- Shared package `freq_pkg` holds:
  - `FILT_LEN_DEF` = 3 and `DIV_DEF` = 10.
  - Range encodings `RANGE_X1` = 1'b0 and `RANGE_DIV` = 1'b1.
- One sub-module, `sync2`: a 2-flop synchroniser with asynchronous active-low reset, reset value 0. It is instantiated twice, once for `sig_raw` and once for `range`.

## Test plan
- **Reset:** assert `reset` low mid-run with `pcnt` = 7 → all outputs 0 immediately. After release, the first accepted `rise` in ÷10 needs 10 rises.
- **×1 latency:** `FILT_LEN`=3, `sig_raw` 0→1 captured at edge k → single `edge_pulse` high in the cycle after edge k+5. 20 clean periods of 10 cycles high / 10 cycles low → exactly 20 pulses.
- **Glitch rejection:** `sig_raw` high pulses of 2 cycles → no `edge_pulse`, one `glitch` per pulse. Pulses of 3 cycles → accepted.
- **÷10:** `range`=1, 95 clean rising edges → 9 `edge_pulse`, final `pcnt` = 5. `sig_out` is high for 5 input periods and low for 5.
- **`clr` collision:** `clr` asserted in the same cycle as `rise` → no pulse, `pcnt` = 0, and the next 10 rises give exactly one pulse.
- **Range switch mid-count:** `range` 1→0 at `pcnt` = 4 → no spurious pulse, and ×1 pulses resume on the next rise.
